// File: rtl/mmio_hub_pkg.sv
// rtl/mmio_hub_pkg.sv - address map, dot FIFO entry layout and LFSR taps for mmio_periph_hub
//
// Shared by mmio_periph_hub and mmio_wr_fifo. Holds:
//   - the default address map (RNG read port, dot X/Y windows, status address)
//   - the dot FIFO entry layout {is_y, id, loc} and its width
//   - Galois LFSR tap masks for the supported widths and a one-step helper
package mmio_hub_pkg;

  // Address map (byte-agnostic word addresses as seen on cpu_addr)
  localparam int RNG_ADDR    = 99;
  localparam int STATUS_ADDR = RNG_ADDR - 1;
  localparam int DOT_BASE    = 100;
  localparam int NUM_DOTS    = 450;
  localparam int DOT_Y_BASE  = DOT_BASE + NUM_DOTS;       // first Y address
  localparam int DOT_END     = DOT_BASE + 2 * NUM_DOTS;   // one past last Y address

  // Dot FIFO entry layout
  localparam int DOT_ID_W  = $clog2(NUM_DOTS);
  localparam int DOT_LOC_W = 32;

  typedef struct packed {
    logic                 is_y;
    logic [DOT_ID_W-1:0]  id;
    logic [DOT_LOC_W-1:0] loc;
  } dot_entry_t;

  localparam int DOT_ENTRY_W = $bits(dot_entry_t);

  // Galois toggle masks: bit (e-1) set for every non-constant term x^e
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;  // x^32+x^22+x^2+x+1
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;       // x^16+x^14+x^13+x^11+1

  // One right-shifting Galois step; narrower LFSRs are zero-extended into 32 bits
  function automatic logic [31:0] galois_step(input logic [31:0] state,
                                              input logic [31:0] taps);
    return (state >> 1) ^ (state[0] ? taps : 32'h0);
  endfunction

endpackage

// File: rtl/mmio_wr_fifo.sv
// rtl/mmio_wr_fifo.sv - synchronous first-word-fall-through FIFO for dot writes
//
// Ports:
//   clock_100  in   clock
//   reset      in   asynchronous, active-high
//   push       in   write push_data (ignored when full unless popping in the same cycle)
//   push_data  in   entry to store
//   pop        in   remove the head (ignored when empty)
//   valid      out  head entry present
//   head       out  head entry, read straight from storage
//   count      out  current occupancy, 0..DEPTH
module mmio_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock_100,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign valid   = (wr_ptr != rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & valid;
  // When full, a simultaneous pop frees the slot the push lands in
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock_100) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_periph_hub.sv
// rtl/mmio_periph_hub.sv - CPU data-memory peripheral hub: RNG port, generation counter, dot FIFO
//
// Optional build macro: MMIO_HUB_STATUS_EN adds a read-only status word at RNG_ADDR-1
// ({overflow, zeros, FIFO occupancy}); a strobed read of it clears fifo_overflow.
//
// Ports:
//   clock_100      in   100 MHz clock
//   reset          in   asynchronous, active-high
//   cpu_stb        in   one-cycle pulse per processor clock edge, qualifies cpu_* and inc_gen
//   cpu_addr       in   data-memory address
//   cpu_we         in   data-memory write enable
//   cpu_wdata      in   write data
//   ram_rdata      in   RAM read data
//   cpu_rdata      out  muxed read data (combinational)
//   inc_gen        in   generation increment request
//   gen_count      out  generation value for the 7-segment driver
//   dot_valid      out  dot FIFO head valid
//   dot_ready      in   VGA accepts the head
//   dot_is_y       out  head is a Y coordinate
//   dot_id         out  head dot index
//   dot_loc        out  head coordinate value
//   fifo_overflow  out  sticky: a dot write was dropped
module mmio_periph_hub #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          NUM_DOTS   = mmio_hub_pkg::NUM_DOTS,
  parameter int          DOT_BASE   = mmio_hub_pkg::DOT_BASE,
  parameter int          RNG_ADDR   = mmio_hub_pkg::RNG_ADDR,
  parameter int          LFSR_W     = 32,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001,
  parameter int          FIFO_DEPTH = 8,
  parameter int          GEN_W      = 14,
  parameter int          GEN_MAX    = 9999
) (
  input  logic                        clock_100,
  input  logic                        reset,
  input  logic                        cpu_stb,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic                        cpu_we,
  input  logic [DATA_W-1:0]           cpu_wdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic [DATA_W-1:0]           cpu_rdata,
  input  logic                        inc_gen,
  output logic [GEN_W-1:0]            gen_count,
  output logic                        dot_valid,
  input  logic                        dot_ready,
  output logic                        dot_is_y,
  output logic [$clog2(NUM_DOTS)-1:0] dot_id,
  output logic [DATA_W-1:0]           dot_loc,
  output logic                        fifo_overflow
);

  import mmio_hub_pkg::dot_entry_t;
  import mmio_hub_pkg::DOT_ENTRY_W;
  import mmio_hub_pkg::galois_step;

  localparam int ID_W  = $clog2(NUM_DOTS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] A_RNG  = ADDR_W'(RNG_ADDR);
  localparam logic [ADDR_W-1:0] A_X_LO = ADDR_W'(DOT_BASE);
  localparam logic [ADDR_W-1:0] A_Y_LO = ADDR_W'(DOT_BASE + NUM_DOTS);
  localparam logic [ADDR_W-1:0] A_END  = ADDR_W'(DOT_BASE + 2 * NUM_DOTS);

  localparam logic [31:0] TAPS = (LFSR_W == 16) ? {16'h0, mmio_hub_pkg::LFSR_TAPS_16}
                                                : mmio_hub_pkg::LFSR_TAPS_32;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_next;
  logic              in_window;
  logic              is_y;
  logic              push;
  logic              pop;
  logic              full;
  logic              drop;
  dot_entry_t        push_entry;
  dot_entry_t        head_entry;
  logic [CNT_W-1:0]  fifo_count;

  // ---------------- LFSR ----------------
  assign lfsr_next = LFSR_W'(galois_step(32'(lfsr_q), TAPS));

  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset)        lfsr_q <= LFSR_SEED[LFSR_W-1:0];
    else if (cpu_stb) lfsr_q <= lfsr_next;
  end

  // ---------------- generation counter ----------------
  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset)
      gen_count <= '0;
    else if (cpu_stb && inc_gen)
      gen_count <= (gen_count == GEN_W'(GEN_MAX)) ? '0 : gen_count + 1'b1;
  end

  // ---------------- dot decode ----------------
  assign in_window = (cpu_addr >= A_X_LO) && (cpu_addr < A_END);
  assign is_y      = (cpu_addr >= A_Y_LO);
  assign push      = cpu_stb & cpu_we & in_window;
  assign pop       = dot_valid & dot_ready;
  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign drop      = push & full & ~pop;

  always_comb begin
    push_entry      = '0;
    push_entry.is_y = is_y;
    push_entry.id   = ID_W'(cpu_addr - (is_y ? A_Y_LO : A_X_LO));
    push_entry.loc  = cpu_wdata;
  end

  mmio_wr_fifo #(
    .WIDTH (DOT_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_100 (clock_100),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .valid     (dot_valid),
    .head      (head_entry),
    .count     (fifo_count)
  );

  assign dot_is_y = head_entry.is_y;
  assign dot_id   = head_entry.id;
  assign dot_loc  = head_entry.loc;

  // ---------------- overflow flag and read mux ----------------
`ifdef MMIO_HUB_STATUS_EN
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(RNG_ADDR - 1);

  logic status_rd;
  assign status_rd = cpu_stb & ~cpu_we & (cpu_addr == A_STATUS);

  // A drop in the same cycle as the clearing read wins
  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset)          fifo_overflow <= 1'b0;
    else if (drop)      fifo_overflow <= 1'b1;
    else if (status_rd) fifo_overflow <= 1'b0;
  end

  always_comb begin
    cpu_rdata = ram_rdata;
    if (cpu_addr == A_STATUS) begin
      cpu_rdata              = '0;
      cpu_rdata[DATA_W-1]    = fifo_overflow;
      cpu_rdata[CNT_W-1:0]   = fifo_count;
    end
    if (cpu_addr == A_RNG) cpu_rdata = DATA_W'(lfsr_q);
  end
`else
  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset)     fifo_overflow <= 1'b0;
    else if (drop) fifo_overflow <= 1'b1;
  end

  always_comb begin
    cpu_rdata = ram_rdata;
    if (cpu_addr == A_RNG) cpu_rdata = DATA_W'(lfsr_q);
  end
`endif

endmodule

// File: tb/tb_mmio_periph_hub.sv
// tb/tb_mmio_periph_hub.sv - self-checking bench for mmio_periph_hub against a queue-based model
module tb_mmio_periph_hub;

  logic        clock_100 = 1'b0;
  logic        reset;
  logic        cpu_stb;
  logic [31:0] cpu_addr;
  logic        cpu_we;
  logic [31:0] cpu_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] cpu_rdata;
  logic        inc_gen;
  logic [13:0] gen_count;
  logic        dot_valid;
  logic        dot_ready;
  logic        dot_is_y;
  logic [8:0]  dot_id;
  logic [31:0] dot_loc;
  logic        fifo_overflow;

  mmio_periph_hub dut (
    .clock_100     (clock_100),
    .reset         (reset),
    .cpu_stb       (cpu_stb),
    .cpu_addr      (cpu_addr),
    .cpu_we        (cpu_we),
    .cpu_wdata     (cpu_wdata),
    .ram_rdata     (ram_rdata),
    .cpu_rdata     (cpu_rdata),
    .inc_gen       (inc_gen),
    .gen_count     (gen_count),
    .dot_valid     (dot_valid),
    .dot_ready     (dot_ready),
    .dot_is_y      (dot_is_y),
    .dot_id        (dot_id),
    .dot_loc       (dot_loc),
    .fifo_overflow (fifo_overflow)
  );

  always #5 clock_100 = ~clock_100;

  int passed = 0;
  int total  = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_y;
    int          id;
    logic [31:0] loc;
  } ent_t;

  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic [31:0] m_lfsr;
  logic [31:0] m_mask;
  int          m_gen;
  ent_t        q[$];
  bit          m_ovf;

  function automatic logic [31:0] poly_mask();
    int exps[4] = '{32, 22, 2, 1};
    logic [31:0] m = 0;
    foreach (exps[i]) m |= (32'h1 << (exps[i] - 1));
    return m;
  endfunction

  task automatic m_reset();
    m_lfsr = SEED;
    m_gen  = 0;
    q.delete();
    m_ovf  = 0;
  endtask

  function automatic logic [31:0] exp_rdata();
    if (cpu_addr == 99) return m_lfsr;
`ifdef MMIO_HUB_STATUS_EN
    if (cpu_addr == 98) return ({31'h0, m_ovf} << 31) | 32'(q.size());
`endif
    return ram_rdata;
  endfunction

  // Advance the model by the current inputs, then let the DUT take the same clock edge
  task automatic clk_edge();
    bit   popd;
    ent_t e;
    popd = (q.size() > 0) && dot_ready;
    if (cpu_stb) begin
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? m_mask : 32'h0);
      if (inc_gen) m_gen = (m_gen == 9999) ? 0 : m_gen + 1;
    end
    if (popd) void'(q.pop_front());
`ifdef MMIO_HUB_STATUS_EN
    if (cpu_stb && !cpu_we && cpu_addr == 98) m_ovf = 0;
`endif
    if (cpu_stb && cpu_we && cpu_addr >= 100 && cpu_addr < 1000) begin
      e.is_y = (cpu_addr >= 550);
      e.id   = int'(cpu_addr) - 100 - (e.is_y ? 450 : 0);
      e.loc  = cpu_wdata;
      if (q.size() < 8) q.push_back(e);
      else              m_ovf = 1;
    end
    @(posedge clock_100);
    #1;
  endtask

  task automatic idle();
    cpu_stb   = 0;
    cpu_we    = 0;
    inc_gen   = 0;
    cpu_addr  = 0;
    cpu_wdata = 0;
  endtask

  task automatic reset_dut();
    reset = 1;
    idle();
    dot_ready = 0;
    @(posedge clock_100);
    #1;
    reset = 0;
    m_reset();
  endtask

  task automatic dot_write(input int addr, input logic [31:0] data);
    cpu_stb   = 1;
    cpu_we    = 1;
    cpu_addr  = 32'(addr);
    cpu_wdata = data;
    clk_edge();
    idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1;
    idle();
    dot_ready = 0;
    ram_rdata = 32'h1234_5678;
    repeat (2) @(posedge clock_100);
    #1;
    reset = 0;
    m_reset();
    total++; if (dot_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dot_valid); else passed++;
    total++; if (fifo_overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", fifo_overflow); else passed++;
    total++; if (gen_count !== 14'd0) $display("FAIL reset_gen: got %0d expected 0", gen_count); else passed++;
    cpu_addr = 5;
    #1;
    total++; if (cpu_rdata !== 32'h1234_5678) $display("FAIL reset_ram_mux: got %h expected 12345678", cpu_rdata); else passed++;
  endtask

  task automatic test_lfsr();
    logic [31:0] prev;
    int errs = 0;
    cpu_addr = 99;
    #1;
    total++; if (cpu_rdata !== SEED) $display("FAIL lfsr_seed: got %h expected %h", cpu_rdata, SEED); else passed++;
    prev = cpu_rdata;
    cpu_stb = 1;
    for (int i = 1; i < 3; i++) begin
      clk_edge();
      total++;
      if (cpu_rdata !== m_lfsr || cpu_rdata == 0 || cpu_rdata == prev)
        $display("FAIL lfsr_step%0d: got %h expected %h (prev %h)", i, cpu_rdata, m_lfsr, prev);
      else passed++;
      prev = cpu_rdata;
    end
    for (int i = 0; i < 20000; i++) begin
      clk_edge();
      if (cpu_rdata !== m_lfsr || cpu_rdata == 0) begin
        if (errs == 0) $display("FAIL lfsr_run at %0d: got %h expected %h", i, cpu_rdata, m_lfsr);
        errs++;
      end
    end
    total++; if (errs == 0) passed++;
    idle();
  endtask

  task automatic test_gen();
    int errs = 0;
    cpu_stb = 1;
    inc_gen = 1;
    cpu_addr = 0;
    for (int i = 0; i < 9999; i++) begin
      clk_edge();
      if (gen_count !== 14'(m_gen)) begin
        if (errs == 0) $display("FAIL gen_run at %0d: got %0d expected %0d", i, gen_count, m_gen);
        errs++;
      end
    end
    total++; if (errs == 0) passed++;
    total++; if (gen_count !== 14'd9999) $display("FAIL gen_max: got %0d expected 9999", gen_count); else passed++;
    clk_edge();
    total++; if (gen_count !== 14'd0) $display("FAIL gen_wrap: got %0d expected 0", gen_count); else passed++;
    repeat (3) clk_edge();
    cpu_stb = 0;
    repeat (4) clk_edge();
    total++; if (gen_count !== 14'd3) $display("FAIL gen_no_stb: got %0d expected 3", gen_count); else passed++;
    idle();
  endtask

  task automatic test_dot_order();
    int   addrs[4] = '{100, 549, 550, 1000};
    logic [31:0] datas[4] = '{32'd40, 32'd7, 32'd12, 32'd99};
    ent_t seen[$];
    ent_t e;
    reset_dut();
    dot_ready = 1;
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c < 4) begin
        cpu_stb   = 1;
        cpu_we    = 1;
        cpu_addr  = 32'(addrs[c]);
        cpu_wdata = datas[c];
      end
      #1;
      if (dot_valid === 1'b1) begin
        e.is_y = dot_is_y; e.id = int'(dot_id); e.loc = dot_loc;
        seen.push_back(e);
      end
      clk_edge();
    end
    idle();
    total++; if (seen.size() != 3) $display("FAIL dot_count: got %0d expected 3", seen.size()); else passed++;
    if (seen.size() >= 3) begin
      total++; if (seen[0].is_y !== 0 || seen[0].id != 0 || seen[0].loc !== 40)
        $display("FAIL dot0: got %0d/%0d/%0d expected 0/0/40", seen[0].is_y, seen[0].id, seen[0].loc); else passed++;
      total++; if (seen[1].is_y !== 0 || seen[1].id != 449 || seen[1].loc !== 7)
        $display("FAIL dot1: got %0d/%0d/%0d expected 0/449/7", seen[1].is_y, seen[1].id, seen[1].loc); else passed++;
      total++; if (seen[2].is_y !== 1 || seen[2].id != 0 || seen[2].loc !== 12)
        $display("FAIL dot2: got %0d/%0d/%0d expected 1/0/12", seen[2].is_y, seen[2].id, seen[2].loc); else passed++;
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    for (int i = 0; i < 8; i++) dot_write(100 + i, 32'(i + 1));
    total++; if (dot_valid !== 1 || fifo_overflow !== 0)
      $display("FAIL ovf_full8: got valid=%b ovf=%b expected 1/0", dot_valid, fifo_overflow); else passed++;
    dot_write(200, 32'hDEAD);
    total++; if (fifo_overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", fifo_overflow); else passed++;
    total++; if (dot_id !== 9'd0 || dot_loc !== 32'd1)
      $display("FAIL ovf_head: got id=%0d loc=%0d expected 0/1", dot_id, dot_loc); else passed++;
    // ninth write coincides with a pop
    reset_dut();
    for (int i = 0; i < 8; i++) dot_write(100 + i, 32'(i + 1));
    dot_ready = 1;
    dot_write(200, 32'hBEEF);
    dot_ready = 0;
    total++; if (fifo_overflow !== 1'b0) $display("FAIL ovf_pop_push: got %b expected 0", fifo_overflow); else passed++;
    total++; if (dot_id !== 9'd1 || dot_loc !== 32'd2)
      $display("FAIL ovf_pop_head: got id=%0d loc=%0d expected 1/2", dot_id, dot_loc); else passed++;
  endtask

`ifdef MMIO_HUB_STATUS_EN
  task automatic test_status();
    reset_dut();
    for (int i = 0; i < 9; i++) dot_write(600 + i, 32'(i));
    cpu_addr = 98;
    #1;
    total++; if (cpu_rdata !== 32'h8000_0008) $display("FAIL status1: got %h expected 80000008", cpu_rdata); else passed++;
    cpu_stb = 1;
    clk_edge();
    cpu_stb = 0;
    #1;
    total++; if (cpu_rdata !== 32'h0000_0008) $display("FAIL status2: got %h expected 00000008", cpu_rdata); else passed++;
    total++; if (fifo_overflow !== 1'b0) $display("FAIL status_clear: got %b expected 0", fifo_overflow); else passed++;
    idle();
  endtask
`endif

  task automatic test_random();
    int e_valid = 0, e_head = 0, e_ovf = 0, e_rd = 0, e_gen = 0;
    int sel;
    reset_dut();
    for (int c = 0; c < 800; c++) begin
      cpu_stb   = ($urandom_range(0, 3) != 0);
      cpu_we    = ($urandom_range(0, 2) != 0);
      inc_gen   = $urandom_range(0, 1);
      dot_ready = ($urandom_range(0, 2) == 0);
      cpu_wdata = $urandom;
      ram_rdata = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       cpu_addr = 99;
        1:       cpu_addr = 98;
        2:       cpu_addr = 32'($urandom_range(0, 97));
        3:       cpu_addr = 32'($urandom_range(1000, 5000));
        default: cpu_addr = 32'($urandom_range(100, 999));
      endcase
      #1;
      if (dot_valid !== (q.size() > 0)) begin
        if (e_valid == 0) $display("FAIL rnd_valid at %0d: got %b expected %0d", c, dot_valid, q.size() > 0);
        e_valid++;
      end else if (q.size() > 0 &&
                   {dot_is_y, dot_id, dot_loc} !== {q[0].is_y, 9'(q[0].id), q[0].loc}) begin
        if (e_head == 0) $display("FAIL rnd_head at %0d: got %0d/%0d/%h expected %0d/%0d/%h",
                                  c, dot_is_y, dot_id, dot_loc, q[0].is_y, q[0].id, q[0].loc);
        e_head++;
      end
      if (fifo_overflow !== m_ovf) begin
        if (e_ovf == 0) $display("FAIL rnd_ovf at %0d: got %b expected %0d", c, fifo_overflow, m_ovf);
        e_ovf++;
      end
      if (cpu_rdata !== exp_rdata()) begin
        if (e_rd == 0) $display("FAIL rnd_rdata at %0d: got %h expected %h", c, cpu_rdata, exp_rdata());
        e_rd++;
      end
      if (gen_count !== 14'(m_gen)) begin
        if (e_gen == 0) $display("FAIL rnd_gen at %0d: got %0d expected %0d", c, gen_count, m_gen);
        e_gen++;
      end
      clk_edge();
    end
    idle();
    total++; if (e_valid == 0) passed++;
    total++; if (e_head == 0) passed++;
    total++; if (e_ovf == 0) passed++;
    total++; if (e_rd == 0) passed++;
    total++; if (e_gen == 0) passed++;
  endtask

  task automatic test_async_reset();
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      inc_gen = 1;
      dot_write(300 + i, 32'(i));
    end
    cpu_stb = 1;
    cpu_addr = 99;
    dot_ready = 1;
    clk_edge();
    cpu_stb = 0;
    #2;
    reset = 1;
    #1;
    total++; if (dot_valid !== 1'b0) $display("FAIL areset_valid: got %b expected 0", dot_valid); else passed++;
    total++; if (gen_count !== 14'd0) $display("FAIL areset_gen: got %0d expected 0", gen_count); else passed++;
    total++; if (cpu_rdata !== SEED) $display("FAIL areset_lfsr: got %h expected %h", cpu_rdata, SEED); else passed++;
    @(posedge clock_100);
    #1;
    reset = 0;
    m_reset();
    idle();
    dot_ready = 0;
  endtask

  initial begin
    m_mask = poly_mask();
    reset = 1;
    idle();
    dot_ready = 0;
    ram_rdata = 0;
    m_reset();
    test_reset();
    test_lfsr();
    test_gen();
    test_dot_order();
    test_overflow();
`ifdef MMIO_HUB_STATUS_EN
    test_status();
`endif
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
